// File: rtl/seg7_decoder_rx_if.sv
// -----------------------------------------------------------------------------
// seg7_decoder_rx_if
// Bundles the functional signals of the seven-segment receiver so the
// producer side (master) and the decoder (slave) share one port.
//
//   en          master -> slave  commit enable
//   seg_in      master -> slave  raw 7-segment bus, bit6 = a ... bit0 = g
//   value       slave  -> master last committed hex digit
//   valid       slave  -> master last committed pattern was legal
//   err         slave  -> master last committed pattern was illegal
//   up_pulse    slave  -> master one-cycle pulse, committed value = old+1
//   dn_pulse    slave  -> master one-cycle pulse, committed value = old-1
//   jump_pulse  slave  -> master one-cycle pulse, any other legal change
//   step_cnt    slave  -> master count of value-changing legal commits
//
// Clock and reset are deliberately kept out of the interface; they stay
// plain scalar ports on the decoder.
// -----------------------------------------------------------------------------
interface seg7_decoder_rx_if;
  logic       en;
  logic [6:0] seg_in;
  logic [3:0] value;
  logic       valid;
  logic       err;
  logic       up_pulse;
  logic       dn_pulse;
  logic       jump_pulse;
  logic [7:0] step_cnt;

  modport master (
    output en,
    output seg_in,
    input  value,
    input  valid,
    input  err,
    input  up_pulse,
    input  dn_pulse,
    input  jump_pulse,
    input  step_cnt
  );

  modport slave (
    input  en,
    input  seg_in,
    output value,
    output valid,
    output err,
    output up_pulse,
    output dn_pulse,
    output jump_pulse,
    output step_cnt
  );
endinterface

// File: rtl/seg7_decoder_rx.sv
// -----------------------------------------------------------------------------
// seg7_decoder_rx
// Receives an asynchronous active-high 7-segment bus, synchronizes it,
// waits for the pattern to be stable for STABLE_CYCLES cycles and then
// commits it once: legal patterns update the displayed hex digit and
// report the direction of the change, illegal patterns flag an error.
//
// Ports
//   clk    rising-edge clock, single domain
//   rst_n  asynchronous active-low reset (release sampled on clk)
//   bus    seg7_decoder_rx_if.slave
//            inputs : en, seg_in
//            outputs: value, valid, err, up_pulse, dn_pulse, jump_pulse,
//                     step_cnt (all driven straight from flops)
//
// Pipeline (change sampled into s1 at edge k):
//   k+1 s2 holds new pattern, k+2 s3 catches up and cnt is cleared,
//   cnt reaches STABLE_CYCLES at k+2+STABLE_CYCLES together with
//   commit_q, outputs update one edge later at k+3+STABLE_CYCLES.
// -----------------------------------------------------------------------------
module seg7_decoder_rx #(
  parameter int unsigned STABLE_CYCLES = 3  // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_decoder_rx_if.slave bus
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_PRE = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing committed since reset
    ST_TRACK = 2'd1,  // last commit was a legal digit
    ST_FAULT = 2'd2   // last commit was an illegal pattern
  } state_e;

  // Returns {legal, digit}. Unknown patterns decode to {0, 0}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1111110: res = {1'b1, 4'h0};
      7'b0110000: res = {1'b1, 4'h1};
      7'b1101101: res = {1'b1, 4'h2};
      7'b1111001: res = {1'b1, 4'h3};
      7'b0110011: res = {1'b1, 4'h4};
      7'b1011011: res = {1'b1, 4'h5};
      7'b1011111: res = {1'b1, 4'h6};
      7'b1110000: res = {1'b1, 4'h7};
      7'b1111111: res = {1'b1, 4'h8};
      7'b1111011: res = {1'b1, 4'h9};
      7'b1111101: res = {1'b1, 4'hA};
      7'b0011111: res = {1'b1, 4'hB};
      7'b1001110: res = {1'b1, 4'hC};
      7'b0111101: res = {1'b1, 4'hD};
      7'b1001111: res = {1'b1, 4'hE};
      7'b1000111: res = {1'b1, 4'hF};
      default:    res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  // Front end: synchronizer, history and stability tracking
  logic [6:0] s1_q, s1_d;
  logic [6:0] s2_q, s2_d;
  logic [6:0] s3_q, s3_d;
  logic [3:0] cnt_q, cnt_d;
  logic       commit_q, commit_d;
  logic [6:0] pat_q, pat_d;

  // Back end: FSM and registered outputs
  state_e     state_q, state_d;
  logic [3:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       up_q, up_d;
  logic       dn_q, dn_d;
  logic       jump_q, jump_d;
  logic [7:0] step_q, step_d;

  logic [4:0] dec_s;
  logic       legal_s;
  logic [3:0] digit_s;

  // Synchronizer shift, stability counter and commit detection
  always_comb begin
    s1_d = bus.seg_in;
    s2_d = s1_q;
    s3_d = s2_q;

    if (s2_q != s3_q) begin
      cnt_d = 4'd0;
    end else if (cnt_q < STABLE_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // Only the single STABLE_PRE -> STABLE_MAX step can commit; once the
    // counter saturates a stable period can never commit again, so a
    // period that passed this point with en low is lost for good.
    if (bus.en && (s2_q == s3_q) && (cnt_q == STABLE_PRE)) begin
      commit_d = 1'b1;
    end else begin
      commit_d = 1'b0;
    end

    // Captured alongside commit_q so the decode sees the committed pattern.
    pat_d = s2_q;
  end

  // Front-end registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 7'b0000000;
      s2_q     <= 7'b0000000;
      s3_q     <= 7'b0000000;
      cnt_q    <= 4'd0;
      commit_q <= 1'b0;
      pat_q    <= 7'b0000000;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      pat_q    <= pat_d;
    end
  end

  assign dec_s   = seg_decode(pat_q);
  assign legal_s = dec_s[4];
  assign digit_s = dec_s[3:0];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: every commit moves to TRACK or FAULT by legality
  always_comb begin
    state_d = state_q;
    if (commit_q) begin
      if (legal_s) begin
        state_d = ST_TRACK;
      end else begin
        state_d = ST_FAULT;
      end
    end else begin
      state_d = state_q;
    end
  end

  // FSM outputs: value/flag update, direction classification, step count
  always_comb begin
    value_d = value_q;
    valid_d = valid_q;
    err_d   = err_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    jump_d  = 1'b0;

    if (commit_q) begin
      if (legal_s) begin
        value_d = digit_s;
        valid_d = 1'b1;
        err_d   = 1'b0;
        case (state_q)
          ST_TRACK: begin
            // 4-bit arithmetic gives the F->0 and 0->F wrap for free.
            if (digit_s == (value_q + 4'd1)) begin
              up_d = 1'b1;
            end else if (digit_s == (value_q - 4'd1)) begin
              dn_d = 1'b1;
            end else if (digit_s != value_q) begin
              jump_d = 1'b1;
            end else begin
              jump_d = 1'b0;
            end
          end
          ST_EMPTY: begin
            up_d = 1'b0;
          end
          ST_FAULT: begin
            up_d = 1'b0;
          end
          default: begin
            up_d = 1'b0;
          end
        endcase
      end else begin
        // Illegal commit keeps the last good digit on display.
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    end else begin
      value_d = value_q;
    end

    if (up_d || dn_d || jump_d) begin
      step_d = step_q + 8'd1;
    end else begin
      step_d = step_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 4'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      jump_q  <= 1'b0;
      step_q  <= 8'd0;
    end else begin
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      jump_q  <= jump_d;
      step_q  <= step_d;
    end
  end

  assign bus.value      = value_q;
  assign bus.valid      = valid_q;
  assign bus.err        = err_q;
  assign bus.up_pulse   = up_q;
  assign bus.dn_pulse   = dn_q;
  assign bus.jump_pulse = jump_q;
  assign bus.step_cnt   = step_q;

endmodule

// File: tb/tb_seg7_decoder_rx.sv
// -----------------------------------------------------------------------------
// tb_seg7_decoder_rx
// Directed bench for seg7_decoder_rx (STABLE_CYCLES = 3). A table of
// {pattern, expected outputs} records drives the main commit path; short
// hand-written sequences cover glitch rejection, en gating and reset in the
// middle of a stability count. Inputs change on the falling edge, outputs
// are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_seg7_decoder_rx;

  logic clk = 1'b0;
  logic rst_n;

  seg7_decoder_rx_if bus_if ();

  seg7_decoder_rx #(.STABLE_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] seg;
    logic [3:0] value;
    logic       valid;
    logic       err;
    logic       up;
    logic       dn;
    logic       jump;
    logic [7:0] step;
  } vec_t;

  vec_t vecs [9];
  vec_t prev;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    chk({tag, ".value"}, 32'(bus_if.value),      32'(e.value));
    chk({tag, ".valid"}, 32'(bus_if.valid),      32'(e.valid));
    chk({tag, ".err"},   32'(bus_if.err),        32'(e.err));
    chk({tag, ".up"},    32'(bus_if.up_pulse),   32'(e.up));
    chk({tag, ".dn"},    32'(bus_if.dn_pulse),   32'(e.dn));
    chk({tag, ".jump"},  32'(bus_if.jump_pulse), 32'(e.jump));
    chk({tag, ".step"},  32'(bus_if.step_cnt),   32'(e.step));
  endtask

  // Packs outputs for compact per-cycle checks in the hand sequences.
  function automatic logic [31:0] outs_packed();
    return 32'({bus_if.value, bus_if.valid, bus_if.err, bus_if.up_pulse,
                bus_if.dn_pulse, bus_if.jump_pulse, bus_if.step_cnt});
  endfunction

  function automatic logic [31:0] exp_packed(input logic [3:0] v, input logic vl, input logic er,
                                             input logic u, input logic d, input logic j,
                                             input logic [7:0] s);
    return 32'({v, vl, er, u, d, j, s});
  endfunction

  vec_t quiet;

  initial begin
    // name, seg, value, valid, err, up, dn, jump, step
    vecs[0] = '{"d1_to_2_up",   7'b1101101, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[1] = '{"d2_to_1_dn",   7'b0110000, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[2] = '{"d1_to_F_jump", 7'b1000111, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
    vecs[3] = '{"dF_to_0_up",   7'b1111110, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
    vecs[4] = '{"d0_to_F_dn",   7'b1000111, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5};
    vecs[5] = '{"dF_to_4_jump", 7'b0110011, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6};
    vecs[6] = '{"illegal",      7'b0000001, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd6};
    vecs[7] = '{"fault_to_3",   7'b1111001, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6};
    vecs[8] = '{"d3_to_5_jump", 7'b1011011, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7};

    // Reset with digit 1 already on the bus.
    rst_n         = 1'b0;
    bus_if.en     = 1'b1;
    bus_if.seg_in = 7'b0110000;
    repeat (3) @(posedge clk);
    #1;
    quiet = '{"reset", 7'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    check_outs("reset", quiet);

    // Release between edges; the next rising edge is edge 0.
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("first.before_edge6.valid", 32'(bus_if.valid), 32'd0);
    @(posedge clk);
    #1;
    prev = '{"first", 7'b0110000, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    check_outs("first", prev);
    repeat (3) @(posedge clk);

    // Table-driven commits: old outputs through k+5, new at k+6, pulse gone at k+7.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk) bus_if.seg_in = vecs[i].seg;
      repeat (6) @(posedge clk);
      #1;
      quiet      = prev;
      quiet.up   = 1'b0;
      quiet.dn   = 1'b0;
      quiet.jump = 1'b0;
      check_outs({vecs[i].name, ".pre"}, quiet);
      @(posedge clk);
      #1;
      check_outs(vecs[i].name, vecs[i]);
      @(posedge clk);
      #1;
      quiet      = vecs[i];
      quiet.up   = 1'b0;
      quiet.dn   = 1'b0;
      quiet.jump = 1'b0;
      check_outs({vecs[i].name, ".post"}, quiet);
      repeat (3) @(posedge clk);
      prev = vecs[i];
    end

    // Two-cycle glitch to 1111111 inside a stable 5: no visible change.
    @(negedge clk) bus_if.seg_in = 7'b1111111;
    @(negedge clk);
    @(negedge clk) bus_if.seg_in = 7'b1011011;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      chk("glitch.hold", outs_packed(), exp_packed(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7));
    end

    // Digit 7 stabilizes with en low, then en rises: never commits.
    @(negedge clk) begin
      bus_if.en     = 1'b0;
      bus_if.seg_in = 7'b1110000;
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk("en_low.hold", outs_packed(), exp_packed(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7));
    end
    @(negedge clk) bus_if.en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("en_raised.hold", outs_packed(), exp_packed(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7));
    end

    // Digit 8 with en high commits as a jump from 5.
    @(negedge clk) bus_if.seg_in = 7'b1111111;
    repeat (6) @(posedge clk);
    #1;
    chk("d8.pre", outs_packed(), exp_packed(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7));
    @(posedge clk);
    #1;
    chk("d8.commit", outs_packed(), exp_packed(4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd8));
    @(posedge clk);
    #1;
    chk("d8.post", outs_packed(), exp_packed(4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8));

    // Reset in the middle of counting digit 6: takes effect at once,
    // then the still-present pattern needs the full latency again.
    @(negedge clk) bus_if.seg_in = 7'b1011111;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midreset.async", outs_packed(), exp_packed(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midreset.pre", outs_packed(), exp_packed(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    @(posedge clk);
    #1;
    chk("midreset.commit", outs_packed(), exp_packed(4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_decoder_rx.md
SEG7_DECODER_RX -- requirements
Module: seg7_decoder_rx

Interface
REQ-001 Parameter STABLE_CYCLES, default 3, legal range 1..15; the number of consecutive cycles a synchronized pattern SHALL hold before it is committed.
REQ-002 clk  input  1  single clock domain; all state SHALL change on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; assertion SHALL take effect immediately, and release SHALL be sampled on the rising edge of clk.
REQ-004 en  input  1  commit enable; when low, no commit SHALL occur.
REQ-005 seg_in  input  7  asynchronous 7-segment bus, active-high, bit6=a down to bit0=g.
REQ-006 value  output  4  last committed hex digit.
REQ-007 valid  output  1  high while the last committed pattern was legal.
REQ-008 err  output  1  high while the last committed pattern was illegal.
REQ-009 up_pulse  output  1  one-cycle pulse when the committed value equals old+1 mod 16.
REQ-010 dn_pulse  output  1  one-cycle pulse when the committed value equals old-1 mod 16.
REQ-011 jump_pulse  output  1  one-cycle pulse when a legal commit differs from old by any other amount.
REQ-012 step_cnt  output  8  count of value-changing legal commits, wrapping from 255 to 0.

Function
REQ-013 Legal patterns SHALL be, for digits 0..F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1111101, 0011111, 1001110, 0111101, 1001111, 1000111; every other pattern SHALL be illegal.
REQ-014 seg_in SHALL pass through a 2-flop synchronizer (s1 then s2), followed by a history register s3 loaded from s2 every cycle.
REQ-015 Stability counter: if s2 differs from s3, cnt SHALL clear to 0; otherwise cnt SHALL increment, saturating at STABLE_CYCLES.
REQ-016 A commit SHALL occur on the single cycle in which cnt transitions from STABLE_CYCLES-1 to STABLE_CYCLES while en=1.
REQ-017 If en=0 on that transition, that stable period SHALL never commit until s2 changes again.
REQ-018 Latency: a seg_in change sampled at edge k SHALL update the outputs at edge k+STABLE_CYCLES+3 (edge k+6 at the default).
REQ-019 FSM states SHALL be EMPTY (no commit since reset), TRACK (last commit legal) and FAULT (last commit illegal).
REQ-020 On a legal commit, value SHALL load the decoded digit, valid SHALL go to 1, err SHALL go to 0, and the FSM SHALL go to TRACK.
REQ-021 On an illegal commit, value SHALL hold, valid SHALL go to 0, err SHALL go to 1, and the FSM SHALL go to FAULT.
REQ-022 Direction pulses SHALL fire only on a legal commit from TRACK, and at most one of up_pulse, dn_pulse or jump_pulse SHALL fire.
REQ-023 Wrap-around: F to 0 SHALL produce up_pulse; 0 to F SHALL produce dn_pulse.
REQ-024 A legal commit from EMPTY or FAULT SHALL produce no pulse and no step_cnt change.
REQ-025 A legal commit equal to the current value from TRACK SHALL produce no pulse and no step_cnt change.
REQ-026 step_cnt SHALL increment exactly when up_pulse, dn_pulse or jump_pulse fires.
REQ-027 A glitch shorter than STABLE_CYCLES cycles at s2 SHALL cause no commit and SHALL restart stability counting.

Reset
REQ-028 While rst_n=0: s1, s2 and s3 SHALL be 0000000, cnt 0, value 0, valid 0, err 0, all pulses 0, step_cnt 0, FSM EMPTY.
REQ-029 Reset asserted mid-stability-count SHALL discard the pending pattern; after release, a pattern already present SHALL need a full REQ-018 latency to commit.

Verification
REQ-030 Reset, then hold seg_in=0110000 (digit 1) -> valid=1, value=1 at edge 6 after release, no pulse, step_cnt=0.
REQ-031 From TRACK value=1, drive 1101101 (digit 2) -> up_pulse for exactly one cycle, value=2, step_cnt=1; then 0110000 -> dn_pulse, step_cnt=2.
REQ-032 From TRACK value=F, drive 1111110 (digit 0) -> up_pulse; then 1000111 (digit F) -> dn_pulse; then 0110011 (digit 4) -> jump_pulse.
REQ-033 Drive illegal 0000001 for 5 cycles -> err=1, valid=0, value held; then 1111001 (digit 3) -> valid=1, no pulse, step_cnt unchanged.
REQ-034 Drive a 2-cycle glitch 1111111 within a stable digit 5 -> no commit, outputs unchanged.
REQ-035 Hold en=0 across a change to digit 7, then raise en -> no commit; change to digit 8 with en=1 -> commit, and value=8 jump_pulse if prior value was 5.
